// File: rtl/arb_weight_credit_tracker_if.sv
// Bundle of the configuration, grant and status signals that pass between the
// weighted round-robin arbiter and its credit tracker. The master side drives
// the weights, grant and reload controls. The slave side (the tracker) returns
// the credit state.
interface arb_weight_credit_tracker_if #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 2,
    parameter int P_ROUND_W       = 8
);
    // Configured weights. Requester n occupies n*W..n*W+W-1, and index n*W is the MSB.
    logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_weight_i;
    logic [P_REQUESTER_NUM-1:0]            grant_i;
    logic                                  round_comp_i;
    logic                                  reload_i;

    // Current credits, packed the same way as req_weight_i.
    logic [0:P_REQUESTER_NUM*P_WEIGHT_W-1] req_credit_o;
    logic [P_REQUESTER_NUM-1:0]            req_weight_remain_o;
    logic [P_REQUESTER_NUM-1:0]            req_eligible_o;
    logic                                  round_done_o;
    logic [P_ROUND_W-1:0]                  round_cnt_o;
    logic                                  err_o;

    modport master (
        output req_weight_i,
        output grant_i,
        output round_comp_i,
        output reload_i,
        input  req_credit_o,
        input  req_weight_remain_o,
        input  req_eligible_o,
        input  round_done_o,
        input  round_cnt_o,
        input  err_o
    );

    modport slave (
        input  req_weight_i,
        input  grant_i,
        input  round_comp_i,
        input  reload_i,
        output req_credit_o,
        output req_weight_remain_o,
        output req_eligible_o,
        output round_done_o,
        output round_cnt_o,
        output err_o
    );
endinterface

// File: rtl/arb_weight_credit_tracker.sv
// Per-requester credit store for the weighted round-robin arbiter.
// The tracker loads each requester's weight as credits and spends one credit per grant.
// It reloads all credits on a forced reload, on a completed round, or when every
// credit is exhausted. It counts completed rounds and flags any grant made to a
// requester that has no credit left.
// All outputs come from registers. No input reaches an output combinationally.
module arb_weight_credit_tracker #(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_WEIGHT_W      = 2,
    parameter int P_ROUND_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    arb_weight_credit_tracker_if.slave   bus
);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } state_t;

    typedef logic [P_WEIGHT_W-1:0] credit_t;

    state_t               state;
    state_t               state_nxt;

    credit_t              weight     [P_REQUESTER_NUM];
    credit_t              credit     [P_REQUESTER_NUM];
    credit_t              credit_nxt [P_REQUESTER_NUM];

    logic [P_REQUESTER_NUM-1:0] eligible;
    logic [P_REQUESTER_NUM-1:0] remain;

    logic                 round_done;
    logic                 round_done_nxt;
    logic [P_ROUND_W-1:0] round_cnt;
    logic [P_ROUND_W-1:0] round_cnt_nxt;
    logic                 err;
    logic                 err_nxt;

    // Unpack the MSB-first weight vector into one field per requester.
    always_comb begin
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            weight[i] = bus.req_weight_i[i*P_WEIGHT_W +: P_WEIGHT_W];
        end
    end

    // Derive the status vectors from the credit registers only.
    always_comb begin
        eligible         = '0;
        remain           = '0;
        bus.req_credit_o = '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++) begin
            eligible[i] = (credit[i] != '0);
            remain[i]   = (credit[i] > credit_t'(1));
            bus.req_credit_o[i*P_WEIGHT_W +: P_WEIGHT_W] = credit[i];
        end
    end

    assign bus.req_eligible_o      = eligible;
    assign bus.req_weight_remain_o = remain;
    assign bus.round_done_o        = round_done;
    assign bus.round_cnt_o         = round_cnt;
    assign bus.err_o               = err;

    // Compute the next state and the next credit, round and error values.
    // The reload sources are checked in priority order: forced, round-complete, exhausted.
    always_comb begin
        // NOTE: every signal this block writes gets a default first.
        // A path that leaves a signal unassigned would infer a latch.
        state_nxt      = state;
        credit_nxt     = credit;
        round_done_nxt = 1'b0;
        round_cnt_nxt  = round_cnt;
        err_nxt        = err;

        unique case (state)
            S_LOAD: begin
                // Grant and round inputs are ignored while the first weights load.
                credit_nxt = weight;
                state_nxt  = S_RUN;
            end

            S_RUN: begin
                if (bus.reload_i) begin
                    credit_nxt = weight;
                end else if (bus.round_comp_i && (|bus.grant_i)) begin
                    credit_nxt     = weight;
                    round_done_nxt = 1'b1;
                    round_cnt_nxt  = round_cnt + 1'b1;
                end else if (eligible == '0) begin
                    // Every credit is spent, or every weight is zero: start a fresh round.
                    credit_nxt = weight;
                end else begin
                    // Each granted bit is handled independently.
                    // A multi-hot grant is therefore not an error.
                    for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                        if (bus.grant_i[i]) begin
                            if (credit[i] != '0) begin
                                credit_nxt[i] = credit[i] - 1'b1;
                            end else begin
                                err_nxt = 1'b1;
                            end
                        end
                    end
                end
            end

            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    // FSM state register. Reset always restarts in S_LOAD.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        // Every register then samples values from before the edge.
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Credit, round and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the credit array is reset along with the other state, because it
            // drives the outputs directly and they must read zero during reset.
            for (int i = 0; i < P_REQUESTER_NUM; i++) begin
                credit[i] <= '0;
            end
            round_done <= 1'b0;
            round_cnt  <= '0;
            err        <= 1'b0;
        end else begin
            credit     <= credit_nxt;
            round_done <= round_done_nxt;
            round_cnt  <= round_cnt_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_arb_weight_credit_tracker.sv
// Self-checking bench for arb_weight_credit_tracker.
// A driver applies directed and then random stimulus and steps a behavioural
// model of the credit rules. For each clock edge it queues the expected outputs.
// A monitor pops one entry per cycle and compares it with the DUT.
module tb_arb_weight_credit_tracker;

    localparam int N = 3;
    localparam int W = 2;
    localparam int R = 8;

    typedef struct packed {
        logic [N-1:0][W-1:0] credit;
        logic [N-1:0]        remain;
        logic [N-1:0]        eligible;
        logic                done;
        logic [R-1:0]        cnt;
        logic                err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arb_weight_credit_tracker_if #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W), .P_ROUND_W(R)) bus ();

    arb_weight_credit_tracker #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W), .P_ROUND_W(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t exp_q[$];
    bit   driver_done = 0;

    // Reference model state.
    int m_credit [N];
    bit m_first;     // the first edge after reset only loads the weights
    int m_cnt;
    bit m_err;
    bit m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge.
    task automatic model_step(input int w [N], input logic [N-1:0] g, input logic comp,
                              input logic rel, input logic rst_v);
        bit all_empty;
        all_empty = 1;
        for (int i = 0; i < N; i++) if (m_credit[i] != 0) all_empty = 0;
        m_done = 0;
        if (rst_v) begin
            for (int i = 0; i < N; i++) m_credit[i] = 0;
            m_first = 1;
            m_cnt   = 0;
            m_err   = 0;
        end else if (m_first || rel) begin
            m_credit = w;
            m_first  = 0;
        end else if (comp && g != 0) begin
            m_credit = w;
            m_done   = 1;
            m_cnt    = (m_cnt + 1) % (1 << R);
        end else if (all_empty) begin
            m_credit = w;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (g[i]) begin
                    if (m_credit[i] > 0) m_credit[i] = m_credit[i] - 1;
                    else m_err = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.credit[i]   = W'(m_credit[i]);
            e.remain[i]   = (m_credit[i] > 1);
            e.eligible[i] = (m_credit[i] != 0);
        end
        e.done = m_done;
        e.cnt  = R'(m_cnt);
        e.err  = m_err;
        return e;
    endfunction

    // Apply one cycle of stimulus just after the falling edge, then queue the expected result.
    task automatic do_cycle(input int w0, input int w1, input int w2, input logic [N-1:0] g,
                            input logic comp, input logic rel, input logic rst_v);
        int   w [N];
        exp_t e;
        w[0] = w0; w[1] = w1; w[2] = w2;
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) bus.req_weight_i[i*W +: W] = W'(w[i]);
        bus.grant_i      = g;
        bus.round_comp_i = comp;
        bus.reload_i     = rel;
        if (rst_v && !rst) begin
            rst = 1'b1;
            #1;
            // Async reset must clear the outputs before any clock edge.
            check("async_rst_credit",   32'(bus.req_credit_o), 32'd0);
            check("async_rst_eligible", 32'(bus.req_eligible_o), 32'd0);
            check("async_rst_cnt",      32'(bus.round_cnt_o), 32'd0);
            check("async_rst_err",      32'(bus.err_o), 32'd0);
        end
        rst = rst_v;
        model_step(w, g, comp, rel, rst_v);
        e = model_outputs();
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    // Monitor: compare one queued expectation against the DUT every cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
                check($sformatf("credit[%0d]", i), 32'(bus.req_credit_o[i*W +: W]), 32'(e.credit[i]));
            end
            check("remain",     32'(bus.req_weight_remain_o), 32'(e.remain));
            check("eligible",   32'(bus.req_eligible_o),      32'(e.eligible));
            check("round_done", 32'(bus.round_done_o),        32'(e.done));
            check("round_cnt",  32'(bus.round_cnt_o),         32'(e.cnt));
            check("err",        32'(bus.err_o),               32'(e.err));
        end
    end

    initial begin
        int            wr [N];
        logic [N-1:0]  g;
        int            sel;

        bus.req_weight_i = '0;
        bus.grant_i      = '0;
        bus.round_comp_i = 1'b0;
        bus.reload_i     = 1'b0;
        for (int i = 0; i < N; i++) m_credit[i] = 0;
        m_first = 1; m_cnt = 0; m_err = 0; m_done = 0;

        // Reset, then release with weights {2,1,3}.
        do_cycle(2, 1, 3, 3'b000, 0, 0, 1);
        do_cycle(2, 1, 3, 3'b000, 0, 0, 1);
        do_cycle(2, 1, 3, 3'b000, 0, 0, 0);
        // Grants r0, r1, r0, r2, r2 leave credits at {0,0,1}.
        do_cycle(2, 1, 3, 3'b001, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b010, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b001, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b100, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b100, 0, 0, 0);
        // The final grant with round_comp reloads, pulses round_done and counts the round.
        do_cycle(2, 1, 3, 3'b100, 1, 0, 0);
        do_cycle(2, 1, 3, 3'b000, 0, 0, 0);
        // Grant r1 until its credit is empty, once more to set err, then reload.
        do_cycle(2, 1, 3, 3'b010, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b010, 0, 0, 0);
        do_cycle(2, 1, 3, 3'b000, 0, 1, 0);
        do_cycle(2, 1, 3, 3'b000, 0, 0, 0);
        // All-zero weights: the block reloads every cycle and never becomes eligible.
        do_cycle(0, 0, 0, 3'b000, 0, 1, 0);
        for (int k = 0; k < 4; k++) do_cycle(0, 0, 0, 3'b001, 0, 0, 0);
        // Change the weights mid-round, then apply reload, round_comp and a grant together.
        do_cycle(2, 1, 3, 3'b000, 0, 1, 0);
        do_cycle(2, 1, 3, 3'b001, 0, 0, 0);
        do_cycle(1, 1, 1, 3'b100, 0, 0, 0);
        do_cycle(1, 1, 1, 3'b001, 0, 0, 0);
        do_cycle(1, 1, 1, 3'b010, 1, 1, 0);
        do_cycle(1, 1, 1, 3'b000, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < N; i++) wr[i] = $urandom_range(0, 3);
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int i = 0; i < N; i++) wr[i] = $urandom_range(0, 3);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0)      g = '0;
            else if (sel == 1) g = N'($urandom_range(0, (1 << N) - 1));
            else               g = N'(1 << $urandom_range(0, N - 1));
            do_cycle(wr[0], wr[1], wr[2], g,
                     ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 79) == 0));
        end

        driver_done = 1;
        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
